// File: rtl/branch_resolve.sv
// branch_resolve: conditional branch evaluator with flag forwarding and a
// one-entry hold for branches that must wait on an in-flight flag producer.
// Outcomes (taken, target) are registered; flush is a one-cycle pulse.
module branch_resolve #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [2:0]       flag_in,
  input  logic             flag_pend,
  input  logic             kill,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [IMM_W-1:0] br_imm,
  output logic             br_ready,
  output logic             stall,
  output logic             res_valid,
  output logic             res_taken,
  output logic [PC_W-1:0]  res_target,
  output logic             flush,
  output logic [2:0]       status
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] C_B = 3'b000;

  state_t           r_state;
  logic [2:0]       r_status;
  logic [2:0]       r_cond;
  logic [PC_W-1:0]  r_pc;
  logic [IMM_W-1:0] r_imm;
  logic             r_res_valid;
  logic             r_res_taken;
  logic [PC_W-1:0]  r_res_target;

  logic [2:0]      w_flags;
  logic            w_accept;
  logic            w_defer;
  logic            w_resolve_now;
  logic            w_now_taken;
  logic [PC_W-1:0] w_now_target;
  logic            w_held_taken;
  logic [PC_W-1:0] w_held_target;

  // Flags are {V,N,Z}; codes 101-111 are illegal and never taken.
  function automatic logic f_cond_true(input logic [2:0] cond,
                                       input logic [2:0] flags);
    logic z, n, v;
    z = flags[0];
    n = flags[1];
    v = flags[2];
    case (cond)
      3'b000:  return 1'b1;
      3'b001:  return z;
      3'b010:  return ~z;
      3'b011:  return n ^ v;
      3'b100:  return (n ^ v) | z;
      default: return 1'b0;
    endcase
  endfunction

  // Next PC: pc + 1, plus the sign-extended offset when taken; wraps.
  function automatic logic [PC_W-1:0] f_target(input logic [PC_W-1:0]  pc,
                                               input logic [IMM_W-1:0] imm,
                                               input logic             taken);
    logic [PC_W-1:0] off;
    off = taken ? {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm} : '0;
    return pc + PC_W'(1) + off;
  endfunction

  // Decode handshake and evaluation of both the incoming and the held branch.
  always_comb begin
    br_ready      = (r_state == S_IDLE) & ~kill;
    w_flags       = flag_we ? flag_in : r_status;
    w_accept      = br_valid & br_ready;
    w_defer       = w_accept & (br_cond != C_B) & flag_pend & ~flag_we;
    w_resolve_now = w_accept & ~w_defer;
    w_now_taken   = f_cond_true(br_cond, w_flags);
    w_now_target  = f_target(br_pc, br_imm, w_now_taken);
    w_held_taken  = f_cond_true(r_cond, flag_in);
    w_held_target = f_target(r_pc, r_imm, w_held_taken);
  end

  // Branch FSM with registered outcome; kill outranks flag_we and accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cond       <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_res_valid  <= 1'b0;
      r_res_taken  <= 1'b0;
      r_res_target <= '0;
    end else begin
      // NOTE: res_valid defaults low each cycle so it can only ever pulse;
      // taken/target are left unassigned on idle cycles and therefore hold.
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_defer) begin
            r_cond  <= br_cond;
            r_pc    <= br_pc;
            r_imm   <= br_imm;
            r_state <= S_WAIT;
          end else if (w_resolve_now) begin
            r_res_valid  <= 1'b1;
            r_res_taken  <= w_now_taken;
            r_res_target <= w_now_target;
          end
        end
        S_WAIT: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else if (flag_we) begin
            r_res_valid  <= 1'b1;
            r_res_taken  <= w_held_taken;
            r_res_target <= w_held_target;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Architectural status register: loads on every CMP result, ignores kill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= '0;
    end else if (flag_we) begin
      r_status <= flag_in;
    end
  end

  assign stall      = (r_state == S_WAIT);
  assign res_valid  = r_res_valid;
  assign res_taken  = r_res_taken;
  assign res_target = r_res_target;
  assign flush      = r_res_valid & r_res_taken;
  assign status     = r_status;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table plus randomized traffic,
// both compared every cycle against a behavioural model of the branch rules.
module tb_branch_resolve;

  localparam int PC_W  = 9;
  localparam int IMM_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flag_we;
  logic [2:0]       flag_in;
  logic             flag_pend;
  logic             kill;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic [PC_W-1:0]  br_pc;
  logic [IMM_W-1:0] br_imm;
  logic             br_ready;
  logic             stall;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             flush;
  logic [2:0]       status;

  branch_resolve #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .flag_pend  (flag_pend),
    .kill       (kill),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_pc      (br_pc),
    .br_imm     (br_imm),
    .br_ready   (br_ready),
    .stall      (stall),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_target (res_target),
    .flush      (flush),
    .status     (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       reset;
    logic       flag_we;
    logic [2:0] flag_in;
    logic       flag_pend;
    logic       kill;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [8:0] br_pc;
    logic [7:0] br_imm;
  } in_t;

  typedef struct {
    in_t        in;
    logic       e_valid;
    logic       e_taken;
    logic [8:0] e_target;
    logic [2:0] e_status;
    logic       e_stall;
    logic       chk_data;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit         m_wait;
  logic [2:0] m_status;
  logic [2:0] m_cond;
  int         m_pc;
  int         m_imm;
  logic       m_valid;
  logic       m_taken;
  logic [8:0] m_target;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input int cond, input logic [2:0] flags);
    bit z, n, v;
    z = flags[0];
    n = flags[1];
    v = flags[2];
    if (cond == 0) return 1'b1;
    if (cond == 1) return z;
    if (cond == 2) return !z;
    if (cond == 3) return n != v;
    if (cond == 4) return (n != v) || z;
    return 1'b0;
  endfunction

  function automatic logic [8:0] next_pc(input int pc, input int imm, input bit taken);
    int off, t;
    off = (imm >= 128) ? imm - 256 : imm;
    t = pc + 1 + (taken ? off : 0);
    t = ((t % 512) + 512) % 512;
    return 9'(t);
  endfunction

  task automatic model_resolve(input int cond, input int pc, input int imm, input logic [2:0] flags);
    m_valid  = 1'b1;
    m_taken  = cond_holds(cond, flags);
    m_target = next_pc(pc, imm, m_taken);
  endtask

  task automatic model_reset();
    m_wait   = 1'b0;
    m_status = 3'b000;
    m_valid  = 1'b0;
    m_taken  = 1'b0;
    m_target = 9'h000;
    m_cond   = 3'b000;
    m_pc     = 0;
    m_imm    = 0;
  endtask

  // Advance the model by one clock edge given the inputs held during the cycle.
  task automatic model_step(input in_t v);
    logic [2:0] flags;
    if (v.reset) begin
      model_reset();
    end else begin
      flags   = v.flag_we ? v.flag_in : m_status;
      m_valid = 1'b0;
      if (m_wait) begin
        if (v.kill) m_wait = 1'b0;
        else if (v.flag_we) begin
          model_resolve(int'(m_cond), m_pc, m_imm, v.flag_in);
          m_wait = 1'b0;
        end
      end else if (v.br_valid && !v.kill) begin
        if (v.br_cond != 3'b000 && v.flag_pend && !v.flag_we) begin
          m_wait = 1'b1;
          m_cond = v.br_cond;
          m_pc   = int'(v.br_pc);
          m_imm  = int'(v.br_imm);
        end else begin
          model_resolve(int'(v.br_cond), int'(v.br_pc), int'(v.br_imm), flags);
        end
      end
      if (v.flag_we) m_status = v.flag_in;
    end
  endtask

  // Apply one cycle of inputs, check handshake mid-cycle and outputs after the edge.
  task automatic drive_cycle(input in_t v);
    reset     = v.reset;
    flag_we   = v.flag_we;
    flag_in   = v.flag_in;
    flag_pend = v.flag_pend;
    kill      = v.kill;
    br_valid  = v.br_valid;
    br_cond   = v.br_cond;
    br_pc     = v.br_pc;
    br_imm    = v.br_imm;
    #4;
    if (!v.reset) begin
      check("br_ready", 32'(br_ready), 32'(!m_wait && !v.kill));
      check("stall_pre", 32'(stall), 32'(m_wait));
    end
    @(posedge clk);
    model_step(v);
    #1;
    check("res_valid", 32'(res_valid), 32'(m_valid));
    check("res_taken", 32'(res_taken), 32'(m_taken));
    check("res_target", 32'(res_target), 32'(m_target));
    check("flush", 32'(flush), 32'(m_valid & m_taken));
    check("status", 32'(status), 32'(m_status));
    check("stall", 32'(stall), 32'(m_wait));
  endtask

  function automatic vec_t mk(input logic r, input logic we, input logic [2:0] fin,
                              input logic pend, input logic k, input logic bv,
                              input logic [2:0] c, input logic [8:0] pc, input logic [7:0] imm,
                              input logic ev, input logic et, input logic [8:0] etg,
                              input logic [2:0] es, input logic estall, input logic cd);
    vec_t x;
    x.in.reset     = r;
    x.in.flag_we   = we;
    x.in.flag_in   = fin;
    x.in.flag_pend = pend;
    x.in.kill      = k;
    x.in.br_valid  = bv;
    x.in.br_cond   = c;
    x.in.br_pc     = pc;
    x.in.br_imm    = imm;
    x.e_valid      = ev;
    x.e_taken      = et;
    x.e_target     = etg;
    x.e_status     = es;
    x.e_stall      = estall;
    x.chk_data     = cd;
    return x;
  endfunction

  vec_t vecs[$];
  in_t  rv;

  initial begin
    // Fields: reset we fin pend kill bv cond pc imm | valid taken target status stall chkdata
    vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 0, 9'h000, 3'b000, 0, 1)); // reset
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 0, 9'h000, 3'b000, 0, 1)); // idle
    vecs.push_back(mk(0, 1, 3'b001, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 0, 9'h000, 3'b001, 0, 0)); // CMP Z=1
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 1, 3'd1, 9'h010, 8'h05, 1, 1, 9'h016, 3'b001, 0, 1)); // BEQ taken
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 1, 9'h016, 3'b001, 0, 1)); // hold
    vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 0, 9'h000, 3'b000, 0, 0)); // CMP 000
    vecs.push_back(mk(0, 1, 3'b001, 0, 0, 1, 3'd2, 9'h020, 8'h10, 1, 0, 9'h021, 3'b001, 0, 1)); // BNE fwd
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 1, 3'd0, 9'h1FF, 8'h00, 1, 1, 9'h000, 3'b001, 0, 1)); // wrap up
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 1, 3'd0, 9'h000, 8'h80, 1, 1, 9'h181, 3'b001, 0, 1)); // wrap down
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 1, 3'd7, 9'h050, 8'h03, 1, 0, 9'h051, 3'b001, 0, 1)); // illegal
    vecs.push_back(mk(0, 0, 3'b000, 1, 0, 1, 3'd0, 9'h030, 8'h7F, 1, 1, 9'h0B0, 3'b001, 0, 1)); // B w/ pend
    vecs.push_back(mk(0, 0, 3'b000, 1, 0, 1, 3'd3, 9'h040, 8'hFE, 0, 1, 9'h0B0, 3'b001, 1, 0)); // BLT hold
    vecs.push_back(mk(0, 0, 3'b000, 1, 0, 0, 3'd0, 9'h000, 8'h00, 0, 1, 9'h0B0, 3'b001, 1, 0)); // wait
    vecs.push_back(mk(0, 1, 3'b010, 0, 0, 0, 3'd0, 9'h000, 8'h00, 1, 1, 9'h03F, 3'b010, 0, 1)); // N=1 -> BLT
    vecs.push_back(mk(0, 0, 3'b000, 1, 0, 1, 3'd4, 9'h060, 8'h04, 0, 1, 9'h03F, 3'b010, 1, 0)); // BLE hold
    vecs.push_back(mk(0, 1, 3'b100, 0, 1, 0, 3'd0, 9'h000, 8'h00, 0, 1, 9'h03F, 3'b100, 0, 1)); // kill+we
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 1, 3'd4, 9'h060, 8'h04, 1, 1, 9'h065, 3'b100, 0, 1)); // BLE V=1
    vecs.push_back(mk(0, 0, 3'b000, 0, 1, 1, 3'd0, 9'h070, 8'h01, 0, 1, 9'h065, 3'b100, 0, 1)); // kill idle
    vecs.push_back(mk(0, 0, 3'b000, 1, 0, 1, 3'd1, 9'h080, 8'h02, 0, 1, 9'h065, 3'b100, 1, 0)); // BEQ hold
    vecs.push_back(mk(1, 1, 3'b111, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 0, 9'h000, 3'b000, 0, 1)); // reset WAIT
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'd0, 9'h000, 8'h00, 0, 0, 9'h000, 3'b000, 0, 1)); // idle

    reset = 1'b1; flag_we = 1'b0; flag_in = '0; flag_pend = 1'b0; kill = 1'b0;
    br_valid = 1'b0; br_cond = '0; br_pc = '0; br_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].in);
      check($sformatf("v%0d_valid", i), 32'(res_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_valid & vecs[i].e_taken));
      check($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].e_status));
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      if (vecs[i].chk_data || vecs[i].e_valid) begin
        check($sformatf("v%0d_taken", i), 32'(res_taken), 32'(vecs[i].e_taken));
        check($sformatf("v%0d_target", i), 32'(res_target), 32'(vecs[i].e_target));
      end
    end

    for (int n = 0; n < 3000; n++) begin
      rv.reset     = ($urandom_range(0, 99) == 0);
      rv.flag_we   = ($urandom_range(0, 3) == 0);
      rv.flag_in   = 3'($urandom_range(0, 7));
      rv.flag_pend = 1'($urandom_range(0, 1));
      rv.kill      = ($urandom_range(0, 9) == 0);
      rv.br_valid  = ($urandom_range(0, 3) != 0);
      rv.br_cond   = 3'($urandom_range(0, 7));
      rv.br_pc     = 9'($urandom_range(0, 511));
      rv.br_imm    = 8'($urandom_range(0, 255));
      drive_cycle(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
